// File: rtl/seg7_pkg.sv
// Shared constants, digit type and helpers for the 8-digit 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  typedef logic [3:0] digit_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Index of the most significant nonzero digit, 0 when every digit is zero
  function automatic logic [2:0] msd_of(input digit_t d [NUM_DIGITS]);
    logic [2:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (d[i] != '0) m = 3'(i);
    return m;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit value to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 8-digit scan driver with once-per-frame snapshot.
// Optional macro LEADING_ZERO_BLANK_EN darkens slots above the most significant nonzero digit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic [3:0] digit5,
  input  logic [3:0] digit6,
  input  logic [3:0] digit7,
  input  logic [7:0] dp_in,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] prescaler;
  logic [2:0]    index;
  logic [2:0]    index_next;
  logic          primed;
  logic          tick;
  logic          load;
  logic          lit;
  digit_t        in_digits [NUM_DIGITS];
  digit_t        snap      [NUM_DIGITS];
  digit_t        snap_next [NUM_DIGITS];
  logic [7:0]    dp_snap;
  logic [7:0]    dp_snap_next;
  logic [6:0]    dec_seg;

  assign in_digits[0] = digit0;
  assign in_digits[1] = digit1;
  assign in_digits[2] = digit2;
  assign in_digits[3] = digit3;
  assign in_digits[4] = digit4;
  assign in_digits[5] = digit5;
  assign in_digits[6] = digit6;
  assign in_digits[7] = digit7;

  assign tick = (prescaler == PW'(CLK_DIV - 1));
  // The first edge after reset also counts as a frame boundary
  assign load = (tick && index == 3'd7) || !primed;

  always_comb begin
    index_next   = tick ? index + 3'd1 : index;
    snap_next    = load ? in_digits : snap;
    dp_snap_next = load ? dp_in : dp_snap;
  end

  hex_to_seg7 u_dec (
    .digit (snap_next[index_next]),
    .seg   (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign lit = (index_next <= msd_of(snap_next));
`else
  assign lit = 1'b1;
`endif

  // Outputs come from next-state values so they switch on the same edge as index
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      index       <= '0;
      primed      <= 1'b0;
      dp_snap     <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= tick ? '0 : prescaler + PW'(1);
      index       <= index_next;
      primed      <= 1'b1;
      snap        <= snap_next;
      dp_snap     <= dp_snap_next;
      an          <= lit ? ~(8'd1 << index_next) : '1;
      seg         <= lit ? dec_seg : SEG_BLANK;
      dp          <= lit ? ~dp_snap_next[index_next] : 1'b1;
      frame_start <= load;
    end
  end

endmodule
